// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one byte-wide RAM port between instruction fetch
// (4-byte words) and the load/store buffer (1/2/4-byte reads and writes).
// Each request is split into byte transfers. Read bytes are assembled
// little-endian, and completion is signalled by a one-cycle done pulse.
// Optional macro MEM_ARB_RR_EN: round-robin priority between requesters.
// When the macro is undefined, the LSB always wins over fetch.
module mem_arbiter #(
  parameter int         ADDR_W = 32,
  parameter logic [1:0] IO_HI  = 2'b11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              flush,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [31:0]       if_data,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [1:0]        ls_size,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [31:0]       ls_wdata,
  output logic              ls_done,
  output logic [31:0]       ls_rdata,
  input  logic              io_buffer_full,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr
);

  typedef enum logic [1:0] {IDLE, IF_RD, LS_RD, LS_WR} state_t;

  state_t            r_state;
  logic [2:0]        r_cnt;      // edges elapsed since grant; next edge is E_cnt
  logic [2:0]        r_n;        // byte count of the current transfer
  logic [ADDR_W-1:0] r_base;
  logic [31:0]       r_wdata;
  logic [31:0]       r_word;     // partially assembled read word
  logic [ADDR_W-1:0] r_mem_a;
  logic [7:0]        r_mem_dout;
  logic              r_mem_wr;
  logic              r_if_done;
  logic              r_ls_done;
  logic [31:0]       r_if_data;
  logic [31:0]       r_ls_rdata;

  logic              w_done_hi;
  logic              w_ls_ok;
  logic              w_if_ok;
  logic              w_grant_ls;
  logic              w_grant_if;
  logic [ADDR_W-1:0] w_next_a;
  logic [7:0]        w_wbyte;
  logic [1:0]        w_lane;
  logic [31:0]       w_asm;

  function automatic logic [2:0] size_to_n(input logic [1:0] sz);
    case (sz)
      2'b00:   size_to_n = 3'd1;
      2'b01:   size_to_n = 3'd2;
      default: size_to_n = 3'd4;
    endcase
  endfunction

  // No new grant while a done pulse is still visible to the requesters.
  assign w_done_hi = r_if_done | r_ls_done;
  // Stores into the IO region wait while the IO sink is full.
  assign w_ls_ok   = ls_req & ~(ls_we & (ls_addr[17:16] == IO_HI) & io_buffer_full);
  assign w_if_ok   = if_req & ~flush;

  assign w_next_a  = r_base + ADDR_W'(r_cnt);
  assign w_wbyte   = r_wdata[{r_cnt[1:0], 3'b000} +: 8];
  // Byte k is captured at edge E_(k+2), so the lane is cnt-2 (mod 4).
  assign w_lane    = r_cnt[1:0] - 2'd2;
  assign w_asm     = r_word | ({24'h0, mem_din} << {w_lane, 3'b000});

`ifdef MEM_ARB_RR_EN
  logic r_prio;   // 0 = LSB preferred, 1 = fetch preferred
  logic w_finish;

  assign w_finish = ((r_state == IF_RD) && flush) ||
                    (((r_state == IF_RD) || (r_state == LS_RD)) && (r_cnt == r_n + 3'd1)) ||
                    ((r_state == LS_WR) && (r_cnt == r_n));
  assign w_grant_ls = w_ls_ok & (~r_prio | ~w_if_ok);
  assign w_grant_if = w_if_ok & (r_prio | ~w_ls_ok);

  // Hand priority to the other requester after every completed or aborted grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prio <= 1'b0;
    end else if (rdy && w_finish) begin
      r_prio <= ~r_prio;
    end
  end
`else
  assign w_grant_ls = w_ls_ok;
  assign w_grant_if = w_if_ok & ~w_ls_ok;
`endif

  // Main sequencer: grant, per-byte address/data stepping, assembly and done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= 3'd0;
      r_n        <= 3'd0;
      r_base     <= '0;
      r_wdata    <= 32'h0;
      r_word     <= 32'h0;
      r_mem_a    <= '0;
      r_mem_dout <= 8'h0;
      r_mem_wr   <= 1'b0;
      r_if_done  <= 1'b0;
      r_ls_done  <= 1'b0;
      r_if_data  <= 32'h0;
      r_ls_rdata <= 32'h0;
    end else if (rdy) begin
      r_if_done <= 1'b0;
      r_ls_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!w_done_hi) begin
            if (w_grant_ls) begin
              r_state    <= ls_we ? LS_WR : LS_RD;
              r_n        <= size_to_n(ls_size);
              r_base     <= ls_addr;
              r_wdata    <= ls_wdata;
              r_word     <= 32'h0;
              r_cnt      <= 3'd1;
              r_mem_a    <= ls_addr;
              r_mem_wr   <= ls_we;
              r_mem_dout <= ls_we ? ls_wdata[7:0] : 8'h0;
            end else if (w_grant_if) begin
              r_state    <= IF_RD;
              r_n        <= 3'd4;
              r_base     <= if_addr;
              r_word     <= 32'h0;
              r_cnt      <= 3'd1;
              r_mem_a    <= if_addr;
              r_mem_wr   <= 1'b0;
              r_mem_dout <= 8'h0;
            end
          end
        end
        IF_RD, LS_RD: begin
          if ((r_state == IF_RD) && flush) begin
            r_state <= IDLE;
            r_cnt   <= 3'd0;
          end else begin
            if (r_cnt < r_n) begin
              r_mem_a <= w_next_a;
            end
            if (r_cnt >= 3'd2) begin
              r_word <= w_asm;
            end
            if (r_cnt == r_n + 3'd1) begin
              r_state <= IDLE;
              r_cnt   <= 3'd0;
              if (r_state == IF_RD) begin
                r_if_data <= w_asm;
                r_if_done <= 1'b1;
              end else begin
                r_ls_rdata <= w_asm;
                r_ls_done  <= 1'b1;
              end
            end else begin
              r_cnt <= r_cnt + 3'd1;
            end
          end
        end
        LS_WR: begin
          if (r_cnt == r_n) begin
            r_mem_wr  <= 1'b0;
            r_ls_done <= 1'b1;
            r_state   <= IDLE;
            r_cnt     <= 3'd0;
          end else begin
            r_mem_a    <= w_next_a;
            r_mem_dout <= w_wbyte;
            r_cnt      <= r_cnt + 3'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // A paused cycle must never write RAM, even with a write byte held.
  assign mem_wr   = r_mem_wr & rdy;
  assign mem_a    = r_mem_a;
  assign mem_dout = r_mem_dout;
  assign if_done  = r_if_done;
  assign if_data  = r_if_data;
  assign ls_done  = r_ls_done;
  assign ls_rdata = r_ls_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter with a byte-wide synchronous RAM model.
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        flush;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_data;
  logic        ls_req;
  logic        ls_we;
  logic [1:0]  ls_size;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic        ls_done;
  logic [31:0] ls_rdata;
  logic        io_buffer_full;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;

  logic [7:0]  ram [0:65535];
  logic        ld_en;
  logic [15:0] ld_a;
  logic [7:0]  ld_d;

  int n_cmp;
  int n_fail;

  mem_arbiter #(.ADDR_W(32), .IO_HI(2'b11)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
    .ls_req(ls_req), .ls_we(ls_we), .ls_size(ls_size), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata),
    .io_buffer_full(io_buffer_full), .mem_din(mem_din), .mem_dout(mem_dout),
    .mem_a(mem_a), .mem_wr(mem_wr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM: read data appears one cycle after the address; writes on mem_wr.
  always @(posedge clk) begin
    if (ld_en) ram[ld_a] <= ld_d;
    else if (mem_wr) ram[mem_a[15:0]] <= mem_dout;
    mem_din <= ram[mem_a[15:0]];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [7:0] pre [0:3];
    pre[0] = 8'h13; pre[1] = 8'h05; pre[2] = 8'h00; pre[3] = 8'h00;
    rst = 1'b1; rdy = 1'b1; flush = 1'b0;
    if_req = 1'b0; if_addr = 32'h0;
    ls_req = 1'b0; ls_we = 1'b0; ls_size = 2'b00; ls_addr = 32'h0; ls_wdata = 32'h0;
    io_buffer_full = 1'b0;
    ld_en = 1'b0; ld_a = 16'h0; ld_d = 8'h0;
    for (int i = 0; i < 4; i++) begin
      ld_en = 1'b1; ld_a = 16'h0100 + 16'(i); ld_d = pre[i];
      tick();
    end
    ld_en = 1'b0;
    tick();
    n_cmp++;
    if ({if_done, ls_done, mem_wr} !== 3'b000) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected 000", {if_done, ls_done, mem_wr});
    end
    n_cmp++;
    if (mem_a !== 32'h0 || mem_dout !== 8'h0) begin
      n_fail++; $display("FAIL reset_port: mem_a=%h mem_dout=%h expected 0", mem_a, mem_dout);
    end
    n_cmp++;
    if (if_data !== 32'h0 || ls_rdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_data: if_data=%h ls_rdata=%h expected 0", if_data, ls_rdata);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_fetch();
    if_req = 1'b1; if_addr = 32'h100;
    tick();
    n_cmp++;
    if (mem_a !== 32'h100 || mem_wr !== 1'b0) begin
      n_fail++; $display("FAIL fetch_e0: mem_a=%h wr=%b expected 100/0", mem_a, mem_wr);
    end
    for (int k = 1; k < 4; k++) begin
      tick();
      n_cmp++;
      if (mem_a !== 32'h100 + 32'(k) || if_done !== 1'b0) begin
        n_fail++; $display("FAIL fetch_addr%0d: mem_a=%h done=%b expected %h/0", k, mem_a, if_done, 32'h100 + 32'(k));
      end
    end
    tick();
    n_cmp++;
    if (if_done !== 1'b0) begin
      n_fail++; $display("FAIL fetch_early_done: got %b expected 0", if_done);
    end
    tick();
    n_cmp++;
    if (if_done !== 1'b1 || if_data !== 32'h00000513) begin
      n_fail++; $display("FAIL fetch_done: done=%b data=%h expected 1/00000513", if_done, if_data);
    end
    if_req = 1'b0;
    tick();
    n_cmp++;
    if (if_done !== 1'b0 || if_data !== 32'h00000513) begin
      n_fail++; $display("FAIL fetch_pulse: done=%b data=%h expected 0/00000513", if_done, if_data);
    end
  endtask

  task automatic test_store();
    ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'b01; ls_addr = 32'h2002; ls_wdata = 32'hAABBCCDD;
    tick();
    n_cmp++;
    if ({mem_wr, mem_a, mem_dout} !== {1'b1, 32'h2002, 8'hDD}) begin
      n_fail++; $display("FAIL store_b0: wr=%b a=%h d=%h expected 1/2002/dd", mem_wr, mem_a, mem_dout);
    end
    tick();
    n_cmp++;
    if ({mem_wr, mem_a, mem_dout, ls_done} !== {1'b1, 32'h2003, 8'hCC, 1'b0}) begin
      n_fail++; $display("FAIL store_b1: wr=%b a=%h d=%h done=%b expected 1/2003/cc/0", mem_wr, mem_a, mem_dout, ls_done);
    end
    tick();
    n_cmp++;
    if (mem_wr !== 1'b0 || ls_done !== 1'b1) begin
      n_fail++; $display("FAIL store_done: wr=%b done=%b expected 0/1", mem_wr, ls_done);
    end
    ls_req = 1'b0; ls_we = 1'b0;
    tick();
    n_cmp++;
    if (ram[16'h2002] !== 8'hDD || ram[16'h2003] !== 8'hCC || ls_done !== 1'b0) begin
      n_fail++; $display("FAIL store_ram: %h %h done=%b expected dd cc 0", ram[16'h2002], ram[16'h2003], ls_done);
    end
  endtask

  task automatic test_contention();
    if_req = 1'b1; if_addr = 32'h100;
    ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'b00; ls_addr = 32'h101;
    tick();
    n_cmp++;
    if (mem_a !== 32'h101) begin
      n_fail++; $display("FAIL cont_ls_first: mem_a=%h expected 101", mem_a);
    end
    tick();
    tick();
    n_cmp++;
    if (ls_done !== 1'b1 || ls_rdata !== 32'h00000005 || if_done !== 1'b0) begin
      n_fail++; $display("FAIL cont_ls_done: done=%b rdata=%h if_done=%b expected 1/00000005/0", ls_done, ls_rdata, if_done);
    end
    ls_req = 1'b0;
    tick();
    n_cmp++;
    if (mem_a !== 32'h101 || ls_done !== 1'b0) begin
      n_fail++; $display("FAIL cont_gap: mem_a=%h done=%b expected 101/0", mem_a, ls_done);
    end
    tick();
    n_cmp++;
    if (mem_a !== 32'h100) begin
      n_fail++; $display("FAIL cont_if_grant: mem_a=%h expected 100", mem_a);
    end
    for (int k = 0; k < 4; k++) tick();
    n_cmp++;
    if (if_done !== 1'b0) begin
      n_fail++; $display("FAIL cont_if_early: done=%b expected 0", if_done);
    end
    tick();
    n_cmp++;
    if (if_done !== 1'b1 || if_data !== 32'h00000513) begin
      n_fail++; $display("FAIL cont_if_done: done=%b data=%h expected 1/00000513", if_done, if_data);
    end
    if_req = 1'b0;
    tick();
  endtask

  task automatic test_flush();
    if_req = 1'b1; if_addr = 32'h100;
    tick();
    tick();
    n_cmp++;
    if (mem_a !== 32'h101) begin
      n_fail++; $display("FAIL flush_pre: mem_a=%h expected 101", mem_a);
    end
    flush = 1'b1; if_req = 1'b0;
    ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'b00; ls_addr = 32'h100;
    tick();
    n_cmp++;
    if (mem_a !== 32'h101 || if_done !== 1'b0) begin
      n_fail++; $display("FAIL flush_abort: mem_a=%h done=%b expected 101/0", mem_a, if_done);
    end
    flush = 1'b0;
    tick();
    n_cmp++;
    if (mem_a !== 32'h100) begin
      n_fail++; $display("FAIL flush_ls_grant: mem_a=%h expected 100", mem_a);
    end
    tick();
    tick();
    n_cmp++;
    if (ls_done !== 1'b1 || ls_rdata !== 32'h00000013 || if_done !== 1'b0 || if_data !== 32'h00000513) begin
      n_fail++; $display("FAIL flush_ls_done: done=%b rdata=%h if_done=%b if_data=%h expected 1/13/0/513", ls_done, ls_rdata, if_done, if_data);
    end
    ls_req = 1'b0;
    tick();
  endtask

  task automatic test_io_backpressure();
    io_buffer_full = 1'b1;
    ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'b00; ls_addr = 32'h30000; ls_wdata = 32'h0000005A;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++;
      if (mem_wr !== 1'b0 || ls_done !== 1'b0 || mem_a !== 32'h100) begin
        n_fail++; $display("FAIL io_blocked%0d: wr=%b done=%b a=%h expected 0/0/100", k, mem_wr, ls_done, mem_a);
      end
    end
    io_buffer_full = 1'b0;
    tick();
    n_cmp++;
    if ({mem_wr, mem_a, mem_dout} !== {1'b1, 32'h30000, 8'h5A}) begin
      n_fail++; $display("FAIL io_grant: wr=%b a=%h d=%h expected 1/30000/5a", mem_wr, mem_a, mem_dout);
    end
    tick();
    n_cmp++;
    if (mem_wr !== 1'b0 || ls_done !== 1'b1 || ram[16'h0000] !== 8'h5A) begin
      n_fail++; $display("FAIL io_done: wr=%b done=%b ram=%h expected 0/1/5a", mem_wr, ls_done, ram[16'h0000]);
    end
    ls_req = 1'b0; ls_we = 1'b0;
    tick();
  endtask

  task automatic test_pause();
    ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'b10; ls_addr = 32'h4000; ls_wdata = 32'h44332211;
    tick();
    n_cmp++;
    if ({mem_wr, mem_a, mem_dout} !== {1'b1, 32'h4000, 8'h11}) begin
      n_fail++; $display("FAIL pause_b0: wr=%b a=%h d=%h expected 1/4000/11", mem_wr, mem_a, mem_dout);
    end
    tick();
    rdy = 1'b0;
    #1;
    n_cmp++;
    if (mem_wr !== 1'b0) begin
      n_fail++; $display("FAIL pause_gate: wr=%b expected 0", mem_wr);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++;
      if ({mem_wr, mem_a, mem_dout, ls_done} !== {1'b0, 32'h4001, 8'h22, 1'b0}) begin
        n_fail++; $display("FAIL pause_hold%0d: wr=%b a=%h d=%h done=%b expected 0/4001/22/0", k, mem_wr, mem_a, mem_dout, ls_done);
      end
    end
    rdy = 1'b1;
    #1;
    n_cmp++;
    if ({mem_wr, mem_a, mem_dout} !== {1'b1, 32'h4001, 8'h22}) begin
      n_fail++; $display("FAIL pause_resume: wr=%b a=%h d=%h expected 1/4001/22", mem_wr, mem_a, mem_dout);
    end
    tick();
    n_cmp++;
    if ({mem_wr, mem_a, mem_dout} !== {1'b1, 32'h4002, 8'h33}) begin
      n_fail++; $display("FAIL pause_b2: wr=%b a=%h d=%h expected 1/4002/33", mem_wr, mem_a, mem_dout);
    end
    tick();
    tick();
    n_cmp++;
    if (mem_wr !== 1'b0 || ls_done !== 1'b1) begin
      n_fail++; $display("FAIL pause_done: wr=%b done=%b expected 0/1", mem_wr, ls_done);
    end
    n_cmp++;
    if ({ram[16'h4000], ram[16'h4001], ram[16'h4002], ram[16'h4003]} !== 32'h11223344) begin
      n_fail++; $display("FAIL pause_ram: got %h%h%h%h expected 11223344", ram[16'h4000], ram[16'h4001], ram[16'h4002], ram[16'h4003]);
    end
    ls_req = 1'b0; ls_we = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_read();
    logic saw_done;
    saw_done = 1'b0;
    if_req = 1'b1; if_addr = 32'h100;
    tick();
    tick();
    tick();
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({mem_wr, if_done, ls_done, mem_a, mem_dout, if_data, ls_rdata} !== '0) begin
      n_fail++; $display("FAIL rst_mid: wr=%b a=%h d=%h if_data=%h ls_rdata=%h expected all 0", mem_wr, mem_a, mem_dout, if_data, ls_rdata);
    end
    if_req = 1'b0;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 7; k++) begin
      tick();
      if (if_done !== 1'b0 || ls_done !== 1'b0) saw_done = 1'b1;
    end
    n_cmp++;
    if (saw_done !== 1'b0) begin
      n_fail++; $display("FAIL rst_no_done: saw_done=%b expected 0", saw_done);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    test_reset();
    test_fetch();
    test_store();
    test_contention();
    test_flush();
    test_io_backpressure();
    test_pause();
    test_reset_mid_read();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
